cart_port_responder: RTL and testbench

// Cartridge-side responder for the 68K PORT space (0x200000-0x2FFFFF) on the MVS/AES slot.

---
 rtl/cart_port_pkg.sv | 16 +
 rtl/strobe_sync.sv | 18 +
 rtl/cart_port_responder.sv | 145 ++++++++++++++
 tb/tb_cart_port_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cart_port_pkg.sv
// Shared constants and FSM state encoding for the cartridge PORT-space responder.
package cart_port_pkg;

  localparam int BANK_W = 3;
  localparam int CNT_W  = 4;

  localparam logic [18:0] BANK_REG_ADDR = 19'h7FFF8;
  localparam logic [18:0] ID_REG_ADDR   = 19'h7FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for one active-low port strobe; resets to the inactive (high) level.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/cart_port_responder.sv
// Cartridge responder for 68K PORT space: counted wait, PDTACK handshake,
// P-ROM bank register and banked ROM / ID register read path.
module cart_port_responder
  import cart_port_pkg::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [1:0]  PWAIT_CFG   = 2'b11,
  parameter logic [7:0]  ID_BYTE     = 8'hC3
) (
  input  logic               CLK_24M,
  input  logic               RESET,
  input  logic [18:0]        M68K_ADDR,
  input  logic [15:0]        M68K_DATA_IN,
  output logic [15:0]        M68K_DATA_OUT,
  output logic               DATA_OE,
  input  logic               nPORTOEL,
  input  logic               nPORTOEU,
  input  logic               nPORTWEL,
  input  logic               nPORTWEU,
  output logic               nPWAIT0,
  output logic               nPWAIT1,
  output logic               PDTACK,
  output logic [21:0]        ROM_ADDR,
  input  logic [15:0]        ROM_DATA,
  output logic [BANK_W-1:0]  BANK
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  logic [3:0] strb_raw;
  logic [3:0] strb_s;

  assign strb_raw = {nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU};

  for (genvar g = 0; g < 4; g++) begin : g_sync
    strobe_sync u_sync (
      .clk (CLK_24M),
      .rst (RESET),
      .d_i (strb_raw[g]),
      .q_o (strb_s[g])
    );
  end

  logic acc, wr, rd, wel;
  assign acc = ~&strb_s;
  assign wel = ~strb_s[1];
  assign wr  = ~strb_s[1] | ~strb_s[0];
  assign rd  = acc & ~wr;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [18:0]        addr_q;
  logic               wr_q, wel_q;
  logic [BANK_W-1:0]  bank_q;
  logic [21:0]        rom_addr_q;
  logic [15:0]        dout_q;
  logic               oe_q, pdtack_q;

  // With zero wait cycles the ACK entry happens straight from IDLE, so the
  // access attributes come from the live bus rather than the latched copy.
  logic [18:0] cur_addr_d;
  logic        cur_wr_d, cur_wel_d, enter_ack_d;

  always_comb begin
    cur_addr_d  = addr_q;
    cur_wr_d    = wr_q;
    cur_wel_d   = wel_q;
    enter_ack_d = 1'b0;
    if (state_q == ST_IDLE) begin
      cur_addr_d  = M68K_ADDR;
      cur_wr_d    = wr;
      cur_wel_d   = wel;
      enter_ack_d = acc && (WAIT_INIT == '0);
    end else if (state_q == ST_WAIT) begin
      enter_ack_d = acc && (cnt_q <= CNT_W'(1));
    end
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wel_q      <= 1'b0;
      bank_q     <= '0;
      rom_addr_q <= '0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      pdtack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            addr_q     <= M68K_ADDR;
            wr_q       <= wr;
            wel_q      <= wel;
            rom_addr_q <= {bank_q, M68K_ADDR};
            cnt_q      <= WAIT_INIT;
            oe_q       <= rd;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!acc) begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
          end else if (!enter_ack_d) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_ACK: begin
          if (!acc) begin
            state_q  <= ST_IDLE;
            pdtack_q <= 1'b0;
            oe_q     <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (enter_ack_d) begin
        state_q  <= ST_ACK;
        pdtack_q <= 1'b1;
        if (cur_wr_d && cur_wel_d && cur_addr_d == BANK_REG_ADDR)
          bank_q <= M68K_DATA_IN[BANK_W-1:0];
        if (!cur_wr_d)
          dout_q <= (cur_addr_d == ID_REG_ADDR) ? {ID_BYTE, 5'b0, bank_q} : ROM_DATA;
      end
    end
  end

  logic unused_din;
  assign unused_din = ^M68K_DATA_IN[15:BANK_W];

  assign {nPWAIT1, nPWAIT0} = PWAIT_CFG;
  assign M68K_DATA_OUT      = dout_q;
  assign DATA_OE            = oe_q;
  assign PDTACK             = pdtack_q;
  assign ROM_ADDR           = rom_addr_q;
  assign BANK               = bank_q;

endmodule

// File: tb/tb_cart_port_responder.sv
// Directed and randomized checks of the PORT-space responder against a bank/ROM reference model.
module tb_cart_port_responder;

  logic        CLK_24M = 1'b0;
  logic        RESET;
  logic [18:0] M68K_ADDR;
  logic [15:0] M68K_DATA_IN;
  logic [15:0] M68K_DATA_OUT;
  logic        DATA_OE;
  logic        nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU;
  logic        nPWAIT0, nPWAIT1;
  logic        PDTACK;
  logic [21:0] ROM_ADDR;
  logic [15:0] ROM_DATA;
  logic [2:0]  BANK;

  int checks = 0;
  int errors = 0;

  int          bank_m;
  logic        rom_fixed;
  logic [15:0] rom_val;

  localparam int          LAT      = 6;
  localparam logic [18:0] A_BANK   = 19'h7FFF8;
  localparam logic [18:0] A_ID     = 19'h7FFFF;

  cart_port_responder dut (
    .CLK_24M       (CLK_24M),
    .RESET         (RESET),
    .M68K_ADDR     (M68K_ADDR),
    .M68K_DATA_IN  (M68K_DATA_IN),
    .M68K_DATA_OUT (M68K_DATA_OUT),
    .DATA_OE       (DATA_OE),
    .nPORTOEL      (nPORTOEL),
    .nPORTOEU      (nPORTOEU),
    .nPORTWEL      (nPORTWEL),
    .nPORTWEU      (nPORTWEU),
    .nPWAIT0       (nPWAIT0),
    .nPWAIT1       (nPWAIT1),
    .PDTACK        (PDTACK),
    .ROM_ADDR      (ROM_ADDR),
    .ROM_DATA      (ROM_DATA),
    .BANK          (BANK)
  );

  always #5 CLK_24M = ~CLK_24M;

  function automatic logic [15:0] rom_f(input logic [21:0] x);
    return x[15:0] ^ {x[21:16], 10'h2A5};
  endfunction

  // P-ROM model: one cycle of read latency.
  always @(posedge CLK_24M) ROM_DATA <= rom_fixed ? rom_val : rom_f(ROM_ADDR);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_strb(input logic [3:0] s);
    {nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU} = ~s;
  endtask

  // s = {OEL, OEU, WEL, WEU}, 1 = strobe asserted.
  task automatic access(input string tag, input logic [3:0] s, input logic [18:0] a,
                        input logic [15:0] d);
    logic        is_wr, is_rd;
    logic [21:0] exp_ra;
    logic [15:0] exp_dat;
    int          lat;
    is_wr   = s[1] | s[0];
    is_rd   = (s[3] | s[2]) & ~is_wr;
    exp_ra  = 22'(bank_m * 524288 + int'(a));
    exp_dat = rom_fixed ? rom_val : rom_f(exp_ra);
    if (a == A_ID) exp_dat = 16'hC300 + 16'(bank_m);
    if (s[1] && a == A_BANK) bank_m = int'(d) % 8;

    @(posedge CLK_24M); #1;
    M68K_ADDR    = a;
    M68K_DATA_IN = d;
    drive_strb(s);
    lat = 0;
    while (!PDTACK && lat < 30) begin
      @(posedge CLK_24M); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_bank"}, BANK, bank_m);
    chk({tag, "_oe"}, DATA_OE, is_rd);
    chk({tag, "_romaddr"}, ROM_ADDR, exp_ra);
    if (is_rd) chk({tag, "_data"}, M68K_DATA_OUT, exp_dat);

    drive_strb(4'b0000);
    lat = 0;
    while (PDTACK && lat < 10) begin
      @(posedge CLK_24M); #1;
      lat++;
    end
    chk({tag, "_ackfall"}, PDTACK, 1'b0);
    chk({tag, "_oefall"}, DATA_OE, 1'b0);
  endtask

  initial begin
    logic saw;
    int   n;
    logic [3:0]  s;
    logic [18:0] a;

    RESET = 1'b1;
    M68K_ADDR = '0;
    M68K_DATA_IN = '0;
    drive_strb(4'b0000);
    rom_fixed = 1'b0;
    rom_val = '0;
    bank_m = 0;
    repeat (3) @(posedge CLK_24M);
    #1 RESET = 1'b0;
    repeat (2) @(posedge CLK_24M);
    #1;
    chk("rst_pdtack", PDTACK, 1'b0);
    chk("rst_oe", DATA_OE, 1'b0);
    chk("rst_bank", BANK, 3'd0);
    chk("rst_romaddr", ROM_ADDR, 22'h0);
    chk("rst_dout", M68K_DATA_OUT, 16'h0);
    chk("rst_pwait", {nPWAIT1, nPWAIT0}, 2'b11);

    rom_fixed = 1'b1;
    rom_val   = 16'hBEEF;
    access("plain_rd", 4'b1100, 19'h00010, 16'h0);
    chk("plain_rd_beef", M68K_DATA_OUT, 16'hBEEF);
    rom_fixed = 1'b0;

    access("bank_wr", 4'b0010, A_BANK, 16'h0005);
    chk("bank_is5", BANK, 3'd5);
    access("bank_rd0", 4'b1100, 19'h0, 16'h0);
    chk("bank_romaddr", ROM_ADDR, 22'h280000);
    access("bank_weu", 4'b0001, A_BANK, 16'h0700);
    chk("bank_weu_keep", BANK, 3'd5);

    access("id_rd", 4'b1100, A_ID, 16'h0);
    chk("id_val", M68K_DATA_OUT, 16'hC305);

    // Strobe withdrawn before the wait count expires.
    @(posedge CLK_24M); #1;
    M68K_ADDR = A_BANK;
    M68K_DATA_IN = 16'h0002;
    drive_strb(4'b0010);
    repeat (3) @(posedge CLK_24M);
    #1 drive_strb(4'b0000);
    saw = 1'b0;
    repeat (8) begin
      @(posedge CLK_24M); #1;
      if (PDTACK) saw = 1'b1;
    end
    chk("abort_noack", saw, 1'b0);
    chk("abort_bank", BANK, bank_m);
    access("after_abort", 4'b1100, 19'h00123, 16'h0);

    // Asynchronous reset while acknowledging.
    @(posedge CLK_24M); #1;
    M68K_ADDR = 19'h00042;
    drive_strb(4'b1100);
    n = 0;
    while (!PDTACK && n < 30) begin
      @(posedge CLK_24M); #1;
      n++;
    end
    chk("midrst_ack", PDTACK, 1'b1);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_pdtack", PDTACK, 1'b0);
    chk("midrst_oe", DATA_OE, 1'b0);
    chk("midrst_bank", BANK, 3'd0);
    bank_m = 0;
    drive_strb(4'b0000);
    @(posedge CLK_24M); #1 RESET = 1'b0;
    repeat (3) @(posedge CLK_24M);

    access("oewe", 4'b1010, A_BANK, 16'h0003);
    chk("oewe_bank", BANK, 3'd3);

    for (int i = 0; i < 40; i++) begin
      s = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 3))
        0:       a = A_BANK;
        1:       a = A_ID;
        default: a = 19'($urandom);
      endcase
      access($sformatf("rnd%0d", i), s, a, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
